// File: rtl/qoi_decoder.sv
// Byte-serial QOI chunk decoder: turns a raw chunk byte stream back into RGB pixels.
// Alpha is tracked for the colour-index hash only; each pixel is committed the cycle it is decoded.
module qoi_decoder #(
    parameter logic [7:0] INIT_ALPHA = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] r,
    output logic [7:0] g,
    output logic [7:0] b,
    output logic       out_valid,
    input  logic       out_ready
);
    localparam logic [1:0] S_OP   = 2'd0;
    localparam logic [1:0] S_ARG  = 2'd1;
    localparam logic [1:0] S_EMIT = 2'd2;
    localparam logic [1:0] S_RUN  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [7:0]  op_q, op_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  ar_q, ar_d, ag_q, ag_d, ab_q, ab_d;
    logic [5:0]  run_q, run_d;
    logic [7:0]  pr_q, pg_q, pb_q, pa_q;
    logic [31:0] index_q [0:63];

    logic        accept_s, xfer_s, commit_s, last_s;
    logic [7:0]  nr_s, ng_s, nb_s, na_s, dg_s;
    logic [31:0] entry_s;
    logic [5:0]  hash_s;

    // 6-bit truncated colour hash of a packed {r,g,b,a} pixel
    function automatic logic [5:0] hash6(input logic [31:0] p);
        return p[29:24] * 6'd3 + p[21:16] * 6'd5 + p[13:8] * 6'd7 + p[5:0] * 6'd11;
    endfunction

    assign in_ready  = rst && ((state_q == S_OP) || (state_q == S_ARG));
    assign out_valid = (state_q == S_EMIT) || (state_q == S_RUN);
    assign r         = pr_q;
    assign g         = pg_q;
    assign b         = pb_q;
    assign accept_s  = in_valid && in_ready;
    assign xfer_s    = out_valid && out_ready;
    assign entry_s   = index_q[in_data[5:0]];
    assign hash_s    = hash6({nr_s, ng_s, nb_s, na_s});
    assign dg_s      = {2'b00, op_q[5:0]} - 8'd32;

    // Next-state decode and the pixel produced when a chunk completes
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        ar_d     = ar_q;
        ag_d     = ag_q;
        ab_d     = ab_q;
        run_d    = run_q;
        commit_s = 1'b0;
        last_s   = 1'b0;
        nr_s     = pr_q;
        ng_s     = pg_q;
        nb_s     = pb_q;
        na_s     = pa_q;
        case (state_q)
            S_OP: begin
                if (accept_s) begin
                    op_d  = in_data;
                    cnt_d = 3'd0;
                    if ((in_data == 8'hFE) || (in_data == 8'hFF) || (in_data[7:6] == 2'b10)) begin
                        state_d = S_ARG;
                    end else if (in_data[7:6] == 2'b00) begin
                        {nr_s, ng_s, nb_s, na_s} = entry_s;
                        commit_s = 1'b1;
                        state_d  = S_EMIT;
                    end else if (in_data[7:6] == 2'b01) begin
                        nr_s     = pr_q + {6'd0, in_data[5:4]} - 8'd2;
                        ng_s     = pg_q + {6'd0, in_data[3:2]} - 8'd2;
                        nb_s     = pb_q + {6'd0, in_data[1:0]} - 8'd2;
                        commit_s = 1'b1;
                        state_d  = S_EMIT;
                    end else begin
                        run_d    = in_data[5:0] + 6'd1;
                        commit_s = 1'b1;
                        state_d  = S_RUN;
                    end
                end else begin
                    state_d = S_OP;
                end
            end
            S_ARG: begin
                if (op_q == 8'hFE) begin
                    last_s = (cnt_q == 3'd2);
                end else if (op_q == 8'hFF) begin
                    last_s = (cnt_q == 3'd3);
                end else begin
                    last_s = (cnt_q == 3'd0);
                end
                if (accept_s) begin
                    cnt_d = cnt_q + 3'd1;
                    case (cnt_q)
                        3'd0:    ar_d = in_data;
                        3'd1:    ag_d = in_data;
                        3'd2:    ab_d = in_data;
                        default: ab_d = ab_q;
                    endcase
                    if (last_s) begin
                        commit_s = 1'b1;
                        state_d  = S_EMIT;
                        if (op_q == 8'hFE) begin
                            nr_s = ar_q;
                            ng_s = ag_q;
                            nb_s = in_data;
                        end else if (op_q == 8'hFF) begin
                            nr_s = ar_q;
                            ng_s = ag_q;
                            nb_s = ab_q;
                            na_s = in_data;
                        end else begin
                            // LUMA: red/blue deltas are relative to the green delta
                            nr_s = pr_q + dg_s + {4'd0, in_data[7:4]} - 8'd8;
                            ng_s = pg_q + dg_s;
                            nb_s = pb_q + dg_s + {4'd0, in_data[3:0]} - 8'd8;
                        end
                    end else begin
                        state_d = S_ARG;
                    end
                end else begin
                    state_d = S_ARG;
                end
            end
            S_EMIT: begin
                if (xfer_s) begin
                    state_d = S_OP;
                end else begin
                    state_d = S_EMIT;
                end
            end
            S_RUN: begin
                if (xfer_s) begin
                    if (run_q == 6'd1) begin
                        state_d = S_OP;
                    end else begin
                        run_d = run_q - 6'd1;
                    end
                end else begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_OP;
            end
        endcase
    end

    // State, previous pixel and colour index registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_OP;
            op_q    <= 8'd0;
            cnt_q   <= 3'd0;
            ar_q    <= 8'd0;
            ag_q    <= 8'd0;
            ab_q    <= 8'd0;
            run_q   <= 6'd0;
            pr_q    <= 8'd0;
            pg_q    <= 8'd0;
            pb_q    <= 8'd0;
            pa_q    <= INIT_ALPHA;
            for (int i = 0; i < 64; i++) begin
                index_q[i] <= 32'd0;
            end
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            ar_q    <= ar_d;
            ag_q    <= ag_d;
            ab_q    <= ab_d;
            run_q   <= run_d;
            if (commit_s) begin
                pr_q            <= nr_s;
                pg_q            <= ng_s;
                pb_q            <= nb_s;
                pa_q            <= na_s;
                index_q[hash_s] <= {nr_s, ng_s, nb_s, na_s};
            end
        end
    end
endmodule

// File: tb/tb_qoi_decoder.sv
// Self-checking bench for qoi_decoder: chunk-level reference model, random handshakes.
module tb_qoi_decoder;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] r, g, b;
    logic       out_valid;
    logic       out_ready = 1'b0;

    int vec_cnt = 0;
    int err_cnt = 0;
    int valid_pct = 100;
    int ready_pct = 100;

    logic [7:0]  byte_q [$];
    bit          last_q [$];
    logic [23:0] exp_q  [$];

    logic [7:0]  mr, mg, mb, ma;
    logic [31:0] midx [64];

    always #5 clk = ~clk;

    qoi_decoder #(.INIT_ALPHA(8'hFF)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .r(r), .g(g), .b(b), .out_valid(out_valid), .out_ready(out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        mr = 8'd0; mg = 8'd0; mb = 8'd0; ma = 8'hFF;
        for (int i = 0; i < 64; i++) midx[i] = 32'd0;
        byte_q.delete(); last_q.delete(); exp_q.delete();
    endfunction

    // Commit a decoded pixel to the model and expect it n times
    function automatic void m_emit(int n, logic [7:0] nr, logic [7:0] ng, logic [7:0] nb, logic [7:0] na);
        int h;
        mr = nr; mg = ng; mb = nb; ma = na;
        h = (int'(nr) * 3 + int'(ng) * 5 + int'(nb) * 7 + int'(na) * 11) % 64;
        midx[h] = {nr, ng, nb, na};
        for (int i = 0; i < n; i++) exp_q.push_back({nr, ng, nb});
    endfunction

    function automatic void push(logic [7:0] v, bit last);
        byte_q.push_back(v);
        last_q.push_back(last);
    endfunction

    function automatic void c_rgb(logic [7:0] cr, logic [7:0] cg, logic [7:0] cb);
        push(8'hFE, 1'b0); push(cr, 1'b0); push(cg, 1'b0); push(cb, 1'b1);
        m_emit(1, cr, cg, cb, ma);
    endfunction

    function automatic void c_rgba(logic [7:0] cr, logic [7:0] cg, logic [7:0] cb, logic [7:0] ca);
        push(8'hFF, 1'b0); push(cr, 1'b0); push(cg, 1'b0); push(cb, 1'b0); push(ca, 1'b1);
        m_emit(1, cr, cg, cb, ca);
    endfunction

    function automatic void c_index(int i);
        logic [31:0] e;
        e = midx[i];
        push(8'(i), 1'b1);
        m_emit(1, e[31:24], e[23:16], e[15:8], e[7:0]);
    endfunction

    function automatic void c_diff(int dr, int dg, int db);
        push(8'h40 | 8'((dr + 2) << 4) | 8'((dg + 2) << 2) | 8'(db + 2), 1'b1);
        m_emit(1, mr + 8'(dr), mg + 8'(dg), mb + 8'(db), ma);
    endfunction

    function automatic void c_luma(int dg, int drdg, int dbdg);
        push(8'h80 | 8'(dg + 32), 1'b0);
        push(8'((drdg + 8) << 4) | 8'(dbdg + 8), 1'b1);
        m_emit(1, mr + 8'(dg + drdg), mg + 8'(dg), mb + 8'(dg + dbdg), ma);
    endfunction

    function automatic void c_run(int n);
        push(8'hC0 | 8'(n - 1), 1'b1);
        m_emit(n, mr, mg, mb, ma);
    endfunction

    task automatic run(input int budget);
        int cyc = 0;
        bit hold = 1'b0;
        bit exp_ov = 1'b0;
        logic [23:0] held = 24'd0;
        while ((byte_q.size() > 0 || exp_q.size() > 0) && cyc < budget) begin
            @(negedge clk);
            in_valid  = (byte_q.size() > 0) && ($urandom_range(99) < valid_pct);
            in_data   = in_valid ? byte_q[0] : 8'($urandom);
            out_ready = ($urandom_range(99) < ready_pct);
            #4;
            if (exp_ov) chk("latency", {31'd0, out_valid}, 32'd1);
            exp_ov = 1'b0;
            if (hold) begin
                chk("stall_valid", {31'd0, out_valid}, 32'd1);
                chk("stall_pixel", {8'd0, r, g, b}, {8'd0, held});
            end
            hold = 1'b0;
            if (out_valid) chk("in_ready_low", {31'd0, in_ready}, 32'd0);
            if (in_valid && in_ready) begin
                exp_ov = last_q.pop_front();
                void'(byte_q.pop_front());
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("extra_pixel", {31'd0, out_valid}, 32'd0);
                else chk("pixel", {8'd0, r, g, b}, {8'd0, exp_q.pop_front()});
            end else if (out_valid) begin
                hold = 1'b1;
                held = {r, g, b};
            end
            cyc++;
        end
        chk("timeout", byte_q.size() + exp_q.size(), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #4;
            chk("idle_no_pixel", {31'd0, out_valid}, 32'd0);
            chk("idle_ready", {31'd0, in_ready}, 32'd1);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        #4;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_rgb", {8'd0, r, g, b}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #4;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        m_reset();
    endtask

    initial begin
        m_reset();
        // RGB, then DIFF, then a stalled RUN
        do_reset();
        c_rgb(8'h10, 8'h20, 8'h30);
        run(100);
        c_diff(1, 1, 1);
        run(100);
        ready_pct = 50;
        c_run(3);
        run(200);
        ready_pct = 100;
        idle(3);

        // INDEX recall via hash 21, LUMA, and DIFF wrap from reset state
        do_reset();
        c_rgb(8'h10, 8'h20, 8'h30);
        c_diff(-2, -2, -2);
        c_index(21);
        c_luma(2, 1, 2);
        run(200);
        do_reset();
        c_diff(-2, -2, -2);
        c_run(62);
        c_run(1);
        run(300);

        // Reset during a partial chunk, then RGBA and index hash 14
        do_reset();
        push(8'hFE, 1'b0); push(8'h10, 1'b0); push(8'h20, 1'b0);
        run(50);
        do_reset();
        c_rgba(8'h01, 8'h02, 8'h03, 8'h04);
        c_index(14);
        run(100);
        idle(2);

        // Random chunk mix with random handshakes
        valid_pct = 70;
        ready_pct = 60;
        for (int k = 0; k < 300; k++) begin
            case ($urandom_range(5))
                0: c_rgb(8'($urandom), 8'($urandom), 8'($urandom));
                1: c_rgba(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
                2: c_index(int'($urandom_range(63)));
                3: c_diff(int'($urandom_range(3)) - 2, int'($urandom_range(3)) - 2, int'($urandom_range(3)) - 2);
                4: c_luma(int'($urandom_range(63)) - 32, int'($urandom_range(15)) - 8, int'($urandom_range(15)) - 8);
                default: c_run(int'($urandom_range(1, 20)));
            endcase
        end
        run(40000);
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
